// File: rtl/uart_tx_fifo_arbiter_pkg.sv
// Shared types and default parameters for the UART TX FIFO write-side arbiter.
package uart_arb_pkg;

    localparam int UART_ARB_NUM_REQ     = 4;
    localparam int UART_ARB_DATA_WIDTH  = 8;
    localparam int UART_ARB_MAX_BURST   = 16;
    localparam int UART_ARB_STALL_LIMIT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage : uart_arb_pkg

// File: rtl/uart_tx_fifo_arbiter_if.sv
// Requester-side and FIFO-side signal bundle of the arbiter, plus FSM debug taps.
interface uart_tx_fifo_arbiter_if #(
    parameter int NUM_REQ    = uart_arb_pkg::UART_ARB_NUM_REQ,
    parameter int DATA_WIDTH = uart_arb_pkg::UART_ARB_DATA_WIDTH
) ();
    localparam int IDW = $clog2(NUM_REQ);

    // A beat moves on a cycle where valid and ready are both high; valid never waits on ready,
    // and a requester holding valid keeps data/last stable until the beat is accepted.
    logic [NUM_REQ-1:0]            reqValid_in;
    logic [NUM_REQ-1:0]            reqLast_in;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData_in;
    logic [NUM_REQ-1:0]            reqReady_out;
    logic                          fifoFull_in;
    logic                          fifoWrEn_out;
    logic [DATA_WIDTH-1:0]         fifoData_out;
    logic                          grantValid_out;
    logic [IDW-1:0]                grantId_out;
    uart_arb_pkg::arb_state_t      dbgState_out;
    logic [IDW-1:0]                dbgRrPtr_out;

    modport master (
        output reqValid_in, reqLast_in, reqData_in, fifoFull_in,
        input  reqReady_out, fifoWrEn_out, fifoData_out, grantValid_out, grantId_out,
        input  dbgState_out, dbgRrPtr_out
    );

    modport slave (
        input  reqValid_in, reqLast_in, reqData_in, fifoFull_in,
        output reqReady_out, fifoWrEn_out, fifoData_out, grantValid_out, grantId_out,
        output dbgState_out, dbgRrPtr_out
    );

endinterface : uart_tx_fifo_arbiter_if

// File: rtl/uart_tx_fifo_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request bit searching circularly from rrPtr_i.
module rr_priority_picker #(
    parameter int NUM_REQ = uart_arb_pkg::UART_ARB_NUM_REQ,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqVec_i,
    input  logic [IDW-1:0]     rrPtr_i,
    output logic               anyReq_o,
    output logic [IDW-1:0]     pickId_o
);

    int             idx;
    logic [IDW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit is the last one written.
    always_comb begin
        anyReq_o = 1'b0;
        pickId_o = '0;
        idx      = 0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx  = (int'(rrPtr_i) + i) % NUM_REQ;
            cand = idx[IDW-1:0];
            if (reqVec_i[cand]) begin
                anyReq_o = 1'b1;
                pickId_o = cand;
            end
        end
    end

endmodule : rr_priority_picker

// File: rtl/uart_tx_fifo_arbiter.sv
// Round-robin burst arbiter sharing one UART TX FIFO write port among NUM_REQ requesters.
module uart_tx_fifo_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ     = UART_ARB_NUM_REQ,
    parameter int DATA_WIDTH  = UART_ARB_DATA_WIDTH,
    parameter int MAX_BURST   = UART_ARB_MAX_BURST,
    parameter int STALL_LIMIT = UART_ARB_STALL_LIMIT
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    uart_tx_fifo_arbiter_if.slave  bus
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int SW  = $clog2(STALL_LIMIT + 1);

    arb_state_t      state_q,    state_d;
    logic [IDW-1:0]  rrPtr_q,    rrPtr_d;
    logic [IDW-1:0]  grantId_q,  grantId_d;
    logic [BW-1:0]   beatCnt_q,  beatCnt_d;
    logic [SW-1:0]   stallCnt_q, stallCnt_d;

    logic                  anyReq;
    logic [IDW-1:0]        pickId;
    logic                  granted;
    logic                  selValid;
    logic                  selLast;
    logic [DATA_WIDTH-1:0] selData;
    logic                  xfer;
    logic [NUM_REQ-1:0]    ready;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .reqVec_i (bus.reqValid_in),
        .rrPtr_i  (rrPtr_q),
        .anyReq_o (anyReq),
        .pickId_o (pickId)
    );

    always_comb begin
        selValid = 1'b0;
        selLast  = 1'b0;
        selData  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantId_q == IDW'(i)) begin
                selValid = bus.reqValid_in[i];
                selLast  = bus.reqLast_in[i];
                selData  = bus.reqData_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign granted = (state_q == BURST);
    assign xfer    = granted && selValid && !bus.fifoFull_in;

    always_comb begin
        ready = '0;
        if (granted) begin
            ready[grantId_q] = !bus.fifoFull_in;
        end
    end

    assign bus.reqReady_out   = ready;
    assign bus.fifoWrEn_out   = xfer;
    assign bus.fifoData_out   = granted ? selData : '0;
    assign bus.grantValid_out = granted;
    assign bus.grantId_out    = grantId_q;
    assign bus.dbgState_out   = state_q;
    assign bus.dbgRrPtr_out   = rrPtr_q;

    always_comb begin
        state_d    = state_q;
        rrPtr_d    = rrPtr_q;
        grantId_d  = grantId_q;
        beatCnt_d  = beatCnt_q;
        stallCnt_d = stallCnt_q;
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    grantId_d  = pickId;
                    beatCnt_d  = '0;
                    stallCnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (xfer) begin
                    stallCnt_d = '0;
                    if (selLast || (beatCnt_q == BW'(MAX_BURST - 1))) begin
                        state_d = IDLE;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end else if (selValid) begin
                    // Valid held against a full FIFO: not a requester stall.
                    stallCnt_d = '0;
                end else if (!bus.fifoFull_in) begin
                    if (stallCnt_q == SW'(STALL_LIMIT - 1)) begin
                        state_d = IDLE;
                    end else begin
                        stallCnt_d = stallCnt_q + 1'b1;
                    end
                end
                if (state_d == IDLE) begin
                    rrPtr_d    = (grantId_q == IDW'(NUM_REQ - 1)) ? '0 : grantId_q + 1'b1;
                    beatCnt_d  = '0;
                    stallCnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rrPtr_q    <= '0;
            grantId_q  <= '0;
            beatCnt_q  <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rrPtr_q    <= rrPtr_d;
            grantId_q  <= grantId_d;
            beatCnt_q  <= beatCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule : uart_tx_fifo_arbiter

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Directed bench: writes are scoreboarded against an expected queue, grant timing checked per cycle.
module tb_uart_tx_fifo_arbiter;
    import uart_arb_pkg::*;

    localparam int NR = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_fifo_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .MAX_BURST   (16),
        .STALL_LIMIT (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic [7:0] d);
        bus.reqValid_in[i]          = v;
        bus.reqLast_in[i]           = l;
        bus.reqData_in[i*DW +: DW]  = d;
    endtask

    task automatic push(input int id, input logic [7:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    task automatic reset_dut();
        rst              = 1'b1;
        bus.reqValid_in  = '0;
        bus.reqLast_in   = '0;
        bus.reqData_in   = '0;
        bus.fifoFull_in  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: every FIFO write is popped against the expected queue.
    always @(negedge clk) begin
        if (bus.fifoWrEn_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'h0, bus.fifoData_out}, 32'hFFFF_FFFF);
            end else begin
                check("fifo_write", {16'h0, 8'(bus.grantId_out), bus.fifoData_out},
                      {16'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        bus.reqValid_in = '0;
        bus.reqLast_in  = '0;
        bus.reqData_in  = '0;
        bus.fifoFull_in = 1'b0;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_grantValid", bus.grantValid_out, 0);
        check("rst_ready", bus.reqReady_out, 0);
        check("rst_wren", bus.fifoWrEn_out, 0);
        check("rst_data", bus.fifoData_out, 0);
        check("rst_grantId", bus.grantId_out, 0);
        reset_dut();

        // Single requester, three beats.
        set_req(1, 1, 0, 8'hA1);
        @(negedge clk);
        check("t1_idle_grant", bus.grantValid_out, 0);
        check("t1_idle_ready", bus.reqReady_out, 0);
        step();
        push(1, 8'hA1);
        @(negedge clk);
        check("t1_grantValid", bus.grantValid_out, 1);
        check("t1_grantId", bus.grantId_out, 1);
        check("t1_ready", bus.reqReady_out, 4'b0010);
        step();
        set_req(1, 1, 0, 8'hA2); push(1, 8'hA2);
        step();
        set_req(1, 1, 1, 8'hA3); push(1, 8'hA3);
        step();
        set_req(1, 0, 0, 8'h00);
        @(negedge clk);
        check("t1_released", bus.grantValid_out, 0);
        check("t1_state", bus.dbgState_out, IDLE);
        check("t1_rrptr", bus.dbgRrPtr_out, 2);
        step();

        // Round-robin fairness with single-beat bursts.
        reset_dut();
        for (int i = 0; i < NR; i++) set_req(i, 1, 1, 8'(8'h10 + i));
        for (int i = 0; i < 5; i++) push(i % NR, 8'(8'h10 + (i % NR)));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t2_grantValid", bus.grantValid_out, k % 2);
            if (k % 2 == 1) check("t2_grantId", bus.grantId_out, ((k - 1) / 2) % NR);
            step();
        end
        for (int i = 0; i < NR; i++) set_req(i, 0, 0, 8'h00);
        @(negedge clk);
        check("t2_idle_end", bus.grantValid_out, 0);
        step();

        // MAX_BURST forced release, then req3, then req2 resumes.
        reset_dut();
        set_req(2, 1, 0, 8'h00);
        set_req(3, 1, 1, 8'hB0);
        step();
        for (int b = 0; b < 16; b++) begin
            set_req(2, 1, 0, 8'(b)); push(2, 8'(b));
            @(negedge clk);
            check("t3_grantId", bus.grantId_out, 2);
            step();
        end
        set_req(2, 1, 0, 8'h10);
        @(negedge clk);
        check("t3_bubble", bus.grantValid_out, 0);
        check("t3_rrptr", bus.dbgRrPtr_out, 3);
        step();
        push(3, 8'hB0);
        @(negedge clk);
        check("t3_req3_grant", bus.grantId_out, 3);
        step();
        set_req(3, 0, 0, 8'h00);
        @(negedge clk);
        check("t3_bubble2", bus.grantValid_out, 0);
        step();
        for (int b = 16; b < 20; b++) begin
            set_req(2, 1, (b == 19), 8'(b)); push(2, 8'(b));
            @(negedge clk);
            check("t3_resume_grant", bus.grantId_out, 2);
            step();
        end
        set_req(2, 0, 0, 8'h00);
        step();

        // FIFO back-pressure for five cycles mid-burst.
        reset_dut();
        set_req(1, 1, 0, 8'h50);
        step();
        push(1, 8'h50);
        step();
        set_req(1, 1, 0, 8'h51); push(1, 8'h51);
        step();
        set_req(1, 1, 0, 8'h52);
        bus.fifoFull_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_full_ready", bus.reqReady_out, 0);
            check("t4_full_wren", bus.fifoWrEn_out, 0);
            check("t4_full_grant", bus.grantValid_out, 1);
            step();
        end
        bus.fifoFull_in = 1'b0;
        push(1, 8'h52);
        @(negedge clk);
        check("t4_resume_wren", bus.fifoWrEn_out, 1);
        check("t4_resume_id", bus.grantId_out, 1);
        step();
        set_req(1, 1, 0, 8'h53); push(1, 8'h53);
        step();
        set_req(1, 1, 0, 8'h54); push(1, 8'h54);
        step();
        set_req(1, 1, 1, 8'h55); push(1, 8'h55);
        step();
        set_req(1, 0, 0, 8'h00);
        step();

        // Stall timeout after one beat.
        reset_dut();
        set_req(0, 1, 0, 8'h60);
        set_req(1, 1, 1, 8'h70);
        step();
        push(0, 8'h60);
        step();
        set_req(0, 0, 0, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("t5_stall_grant", bus.grantValid_out, 1);
            check("t5_stall_ready", bus.reqReady_out, 4'b0001);
            step();
        end
        @(negedge clk);
        check("t5_timeout_idle", bus.grantValid_out, 0);
        step();
        push(1, 8'h70);
        @(negedge clk);
        check("t5_next_grant", bus.grantId_out, 1);
        check("t5_next_valid", bus.grantValid_out, 1);
        step();
        set_req(1, 0, 0, 8'h00);
        step();

        // Reset during beat 3 of 5.
        reset_dut();
        set_req(2, 1, 0, 8'h80);
        step();
        push(2, 8'h80);
        step();
        set_req(2, 1, 0, 8'h81); push(2, 8'h81);
        step();
        set_req(2, 1, 0, 8'h82); push(2, 8'h82);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(2, 1, 0, 8'h83);
        set_req(0, 1, 1, 8'h90);
        @(negedge clk);
        check("t6_grantValid", bus.grantValid_out, 0);
        check("t6_ready", bus.reqReady_out, 0);
        check("t6_wren", bus.fifoWrEn_out, 0);
        check("t6_data", bus.fifoData_out, 0);
        check("t6_grantId", bus.grantId_out, 0);
        check("t6_rrptr", bus.dbgRrPtr_out, 0);
        step();
        push(0, 8'h90);
        @(negedge clk);
        check("t6_restart_req0", bus.grantId_out, 0);
        step();
        set_req(0, 0, 0, 8'h00);
        @(negedge clk);
        check("t6_rrptr_after", bus.dbgRrPtr_out, 1);
        step();
        push(2, 8'h83);
        @(negedge clk);
        check("t6_req2_resume", bus.grantId_out, 2);
        step();
        set_req(2, 1, 1, 8'h84); push(2, 8'h84);
        step();
        set_req(2, 0, 0, 8'h00);
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_tx_fifo_arbiter

// File: doc/uart_tx_fifo_arbiter.md
Name: uart_tx_fifo_arbiter

Overview:
Round-robin write-side arbiter that shares one UART TX FIFO among NUM_REQ requesters (e.g. CPU MMIO port, debug monitor, DMA).
- Grants one requester at a time for a burst, ending on last-beat, MAX_BURST beats, or stall timeout.
- Forwards accepted bytes to the FIFO write port, back-pressured by the FIFO full indication.
- Sits between requester valid/ready interfaces and the FIFO write enables/data.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width written to FIFO
MAX_BURST, 16, max beats per grant before forced release (>=1)
STALL_LIMIT, 8, consecutive cycles granted requester may hold valid low before forced release (>=1)

Ports:
clk_in  input  1  single clock, rising edge
rst_in  input  1  synchronous reset, active-high
reqValid_in  input  NUM_REQ  per-requester beat valid
reqLast_in  input  NUM_REQ  per-requester last beat of burst (sampled with valid)
reqData_in  input  NUM_REQ*DATA_WIDTH  packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
reqReady_out  output  NUM_REQ  per-requester beat accept
fifoFull_in  input  1  FIFO full (inverse of FIFO input-ready)
fifoWrEn_out  output  1  FIFO write enable, one byte per cycle high
fifoData_out  output  DATA_WIDTH  FIFO write data
grantValid_out  output  1  a requester currently holds the grant
grantId_out  output  $clog2(NUM_REQ)  index of granted requester

Behaviour:
- Reset (rst_in high at an edge): state IDLE, rrPtr=0, grantId=0, beatCnt=0, stallCnt=0.
  - All outputs are 0: reqReady_out, fifoWrEn_out, fifoData_out, grantValid_out, grantId_out.
  - Reset mid-burst aborts the burst. Beats already written stay in the FIFO.
- States: IDLE, BURST.
- IDLE:
  - No ready is asserted and no write occurs.
  - If any reqValid_in bit is set, pick the first set bit searching circularly from rrPtr upward.
  - Register the pick into grantId and go to BURST. Arbitration latency is 1 cycle.
- BURST:
  - grantValid_out=1.
  - reqReady_out[grantId] = !fifoFull_in. All other ready bits are 0.
  - Transfer occurs when reqValid_in[grantId] && reqReady_out[grantId].
  - fifoWrEn_out = transfer, and is combinational from the inputs in the same cycle.
  - fifoData_out = reqData_in[grantId] while in BURST, else 0.
  - beatCnt increments on each transfer.
  - Release conditions, evaluated on a transfer:
    - reqLast_in[grantId]=1.
    - The transfer is beat number MAX_BURST (beatCnt==MAX_BURST-1).
  - Release condition, evaluated when no transfer occurs:
    - stallCnt increments on cycles where reqValid_in[grantId]=0. It clears on any cycle where valid=1.
    - fifoFull_in stalls do not count toward stallCnt.
    - Release when stallCnt reaches STALL_LIMIT-1 and valid is still low.
  - On release: rrPtr = (grantId+1) mod NUM_REQ, counters clear, next state IDLE.
  - There is always exactly one IDLE bubble between bursts.
- Last and limit on the same beat: a single release.
- The grant never moves while fifoFull_in=1. The burst simply stalls.
- A non-granted requester's valid/last/data are ignored.
- Requester validity is not checked by the arbiter. A requester holding valid while waiting must keep data stable (protocol rule).
- Counter widths: beatCnt $clog2(MAX_BURST+1), stallCnt $clog2(STALL_LIMIT+1). Pointer wrap is modulo NUM_REQ, which need not be a power of two.

Decomposition:
- Package uart_arb_pkg:
  - arb_state_t enum (IDLE, BURST).
  - Default-parameter constants UART_ARB_NUM_REQ, UART_ARB_MAX_BURST, UART_ARB_STALL_LIMIT.
- Sub-module rr_priority_picker:
  - Combinational.
  - Inputs: request vector and rrPtr.
  - Outputs: anyReq and pickId (circular first-set search).
  - Reusable by future RX-side schedulers.

Test Plan:
- Reset then single requester: req1 sends 3 bytes 0xA1,0xA2,0xA3 with last on 0xA3.
  - grantId=1 one cycle after valid.
  - fifoWrEn high exactly 3 cycles with those bytes in order.
  - Then IDLE, rrPtr=2.
- Round-robin fairness: all 4 requesters valid continuously, each burst 1 beat with last=1.
  - Grant order 0,1,2,3,0.
  - One IDLE cycle between grants.
- MAX_BURST limit: req2 streams 20 bytes 0x00..0x13, never asserting last.
  - Release after 16 writes (0x00..0x0F).
  - req3 (if valid) is granted next.
  - req2 re-granted later resumes at 0x10.
- FIFO back-pressure: fifoFull_in high for 5 cycles mid-burst.
  - reqReady and fifoWrEn are 0 those cycles, with no release and no lost or duplicated byte.
  - Writes resume on the first not-full cycle.
- Stall timeout: granted req0 drops valid after 1 beat.
  - Release exactly after 8 low-valid cycles.
  - The next cycle is IDLE, and req1 is granted on the following cycle.
- Reset mid-burst: rst_in high during beat 3 of 5.
  - All outputs are 0 the next cycle and rrPtr=0.
  - After reset the arbitration restarts from req0.
